// File: rtl/oclib_word_to_bc.sv
// ---------------------------------------------------------------------------
// oclib_pkg / oclib_word_to_bc
//
// Purpose:
//   Serializes one WordWidth-bit word into the 8-bit byte channel. Bytes leave
//   MSB-first. When PrefixLength is set, a length byte (WordBytes) goes out
//   first. Between payload bytes the shift register moves one byte left. The
//   move is done group by group (ShiftFanout flops per group), leftmost group
//   first, so no single control net has to fan out to the whole register.
//
// Ports:
//   clock      in   sole clock, posedge
//   resetN     in   asynchronous active-low reset
//   wordData   in   word to transmit, sampled on the accept edge only
//   wordValid  in   producer has a word
//   wordReady  out  block can take a word (registered)
//   bc         out  byte channel: .data[7:0], .valid
//   bcFb       in   byte channel feedback: .ready
//   dbgState   out  current FSM state (state_e encoding)
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The source holds valid and its data stable until
// that edge. Ready seen while valid is low has no effect. bc.valid drops on
// the edge after every byte transfer, so two different bytes never show
// valid in back-to-back cycles.
// ---------------------------------------------------------------------------
package oclib_pkg;

    localparam bit True  = 1'b1;
    localparam bit False = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } bc_8b_s;

    typedef struct packed {
        logic ready;
    } bc_8b_fb_s;

endpackage

module oclib_word_to_bc #(
    parameter int WordWidth    = 64,
    parameter int ShiftFanout  = 16,
    parameter bit PrefixLength = oclib_pkg::True
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic [WordWidth-1:0] wordData,
    input  logic                 wordValid,
    output logic                 wordReady,
    output oclib_pkg::bc_8b_s    bc,
    input  oclib_pkg::bc_8b_fb_s bcFb,
    output logic [2:0]           dbgState
);

    localparam int WordBytes   = (WordWidth + 7) / 8;
    localparam int SregWidth   = WordBytes * 8;
    localparam int ShiftGroups = (WordWidth + ShiftFanout - 1) / ShiftFanout;
    localparam int CountWidth  = $clog2(WordBytes + 1);
    localparam logic [7:0] PrefixByte = 8'(WordBytes);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(WordBytes - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPrefix = 3'd1,
        StGap    = 3'd2,
        StSend   = 3'd3,
        StShift  = 3'd4
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [SregWidth-1:0]   r_sreg;
    logic [ShiftGroups-1:0] r_pipe;       // bit 0 = leftmost group
    logic [CountWidth-1:0]  r_count;
    logic                   r_word_ready;
    logic                   r_bc_valid;

    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_last_byte;
    logic                   w_last_group;
    logic                   w_start_shift;
    logic [SregWidth-1:0]   w_sreg_shl;
    logic [SregWidth-1:0]   w_grp_shift;  // per-bit enable from its group's pipe bit

    assign w_accept      = wordValid && r_word_ready;
    assign w_xfer        = r_bc_valid && bcFb.ready;
    assign w_last_byte   = (r_count == LastCount);
    assign w_last_group  = r_pipe[ShiftGroups-1];
    assign w_start_shift = (r_state == StSend) && w_xfer && !w_last_byte;
    assign w_sreg_shl    = r_sreg << 8;

    // Bit i belongs to group (SregWidth-1-i)/ShiftFanout counted from the top.
    // Pad bits that fall below the last full group are folded into the last
    // group; they only ever read from bits of the same group, which still hold
    // their old value when that group shifts.
    for (genvar i = 0; i < SregWidth; i++) begin : g_bit
        localparam int RawGrp = (SregWidth - 1 - i) / ShiftFanout;
        localparam int Grp    = (RawGrp < ShiftGroups) ? RawGrp : ShiftGroups - 1;
        assign w_grp_shift[i] = r_pipe[Grp];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_nxt = PrefixLength ? StPrefix : StSend;
            StPrefix: if (w_xfer) w_state_nxt = StGap;
            StGap:    w_state_nxt = StSend;
            StSend:   if (w_xfer) w_state_nxt = w_last_byte ? StIdle : StShift;
            StShift:  if (w_last_group) w_state_nxt = StSend;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= StIdle;
            r_word_ready <= 1'b0;
            r_bc_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // Handshake flags follow the state being entered, so both change
            // on the same edge as the state.
            r_word_ready <= (w_state_nxt == StIdle);
            r_bc_valid   <= (w_state_nxt == StPrefix) || (w_state_nxt == StSend);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sreg  <= '0;
            r_pipe  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_sreg  <= SregWidth'(wordData);
                r_pipe  <= '0;
                r_count <= '0;
            end else begin
                // r_pipe is all-zero outside StShift, so this is a no-op there.
                r_sreg <= (r_sreg & ~w_grp_shift) | (w_sreg_shl & w_grp_shift);
                if (w_start_shift) begin
                    r_pipe <= ShiftGroups'(1);
                end else begin
                    r_pipe <= r_pipe << 1;
                end
                if ((r_state == StSend) && w_xfer) begin
                    r_count <= r_count + CountWidth'(1);
                end
            end
        end
    end

    always_comb begin
        bc       = '0;
        bc.valid = r_bc_valid;
        if (r_state == StPrefix) begin
            bc.data = PrefixByte;
        end else if (r_state == StSend) begin
            bc.data = r_sreg[SregWidth-1 -: 8];
        end
    end

    assign wordReady = r_word_ready;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_oclib_word_to_bc.sv
// ---------------------------------------------------------------------------
// tb_oclib_word_to_bc
//   Three instances share one clock, reset, word bus and byte-channel ready:
//     dut_a: WordWidth=64, PrefixLength=1   (sel=0)
//     dut_b: WordWidth=64, PrefixLength=0   (sel=1)
//     dut_c: WordWidth=12, PrefixLength=1   (sel=2)
//   Only the selected instance sees wordValid. A negedge process drives the
//   producer queue and the ready line, and logs every byte transfer together
//   with the index of the rising edge it happens on.
// ---------------------------------------------------------------------------
module tb_oclib_word_to_bc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b0;
    logic [63:0] word_data  = '0;
    logic        word_valid = 1'b0;
    logic        bc_ready   = 1'b0;
    int          sel        = 0;

    logic wr_a, wr_b, wr_c;
    logic [2:0] st_a, st_b, st_c;
    oclib_pkg::bc_8b_s    bc_a, bc_b, bc_c;
    oclib_pkg::bc_8b_fb_s fb;
    assign fb.ready = bc_ready;

    oclib_word_to_bc #(.WordWidth(64), .ShiftFanout(16), .PrefixLength(1'b1)) dut_a (
        .clock(clk), .resetN(rst_n), .wordData(word_data),
        .wordValid(word_valid && (sel == 0)), .wordReady(wr_a),
        .bc(bc_a), .bcFb(fb), .dbgState(st_a));

    oclib_word_to_bc #(.WordWidth(64), .ShiftFanout(16), .PrefixLength(1'b0)) dut_b (
        .clock(clk), .resetN(rst_n), .wordData(word_data),
        .wordValid(word_valid && (sel == 1)), .wordReady(wr_b),
        .bc(bc_b), .bcFb(fb), .dbgState(st_b));

    oclib_word_to_bc #(.WordWidth(12), .ShiftFanout(16), .PrefixLength(1'b1)) dut_c (
        .clock(clk), .resetN(rst_n), .wordData(word_data[11:0]),
        .wordValid(word_valid && (sel == 2)), .wordReady(wr_c),
        .bc(bc_c), .bcFb(fb), .dbgState(st_c));

    logic       cur_ready, cur_valid;
    logic [7:0] cur_data;
    always_comb begin
        cur_ready = 1'b0;
        cur_valid = 1'b0;
        cur_data  = 8'h00;
        case (sel)
            0: begin cur_ready = wr_a; cur_valid = bc_a.valid; cur_data = bc_a.data; end
            1: begin cur_ready = wr_b; cur_valid = bc_b.valid; cur_data = bc_b.data; end
            2: begin cur_ready = wr_c; cur_valid = bc_c.valid; cur_data = bc_c.data; end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] tx_q[$];
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    int          acc_t[$];
    int          stab_viol   = 0;
    int          consec_viol = 0;
    int          rdy_rise    = -1;
    bit          rdy_random  = 1'b0;
    logic        rdy_val     = 1'b1;
    logic        prev_valid  = 1'b0;
    logic        prev_xfer   = 1'b0;
    logic        prev_ready  = 1'b0;
    logic [7:0]  prev_data   = 8'h00;

    // Edge numbering: at a negedge, cyc counts the rising edges already seen,
    // so the next rising edge is cyc+1.
    always @(negedge clk) begin
        bc_ready = rdy_random ? ($urandom_range(0, 99) < 30) : rdy_val;
        word_valid = (tx_q.size() > 0);
        if (word_valid) word_data = tx_q[0];
        if (word_valid && cur_ready) begin
            acc_t.push_back(cyc + 1);
            void'(tx_q.pop_front());
        end
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_xfer && cur_valid) consec_viol++;
            if (prev_valid && !prev_xfer && (!cur_valid || cur_data != prev_data)) stab_viol++;
            if (cur_ready && !prev_ready) rdy_rise = cyc;
            if (cur_valid && bc_ready) begin
                rx_q.push_back(cur_data);
                rx_t.push_back(cyc + 1);
            end
            prev_valid = cur_valid;
            prev_data  = cur_data;
            prev_xfer  = cur_valid && bc_ready;
            prev_ready = cur_ready;
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        rx_t.delete();
        acc_t.delete();
        stab_viol   = 0;
        consec_viol = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] model_byte_a(input logic [63:0] w, input int k);
        if (k == 0) return 8'h08;
        return w[63 - 8 * (k - 1) -: 8];
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({wr_a, wr_b, wr_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_word_ready got=%b want=000", {wr_a, wr_b, wr_c});
        end
        n_vec++;
        if ({bc_a.valid, bc_b.valid, bc_c.valid} !== 3'b000) begin
            n_err++; $display("FAIL reset_bc_valid got=%b want=000", {bc_a.valid, bc_b.valid, bc_c.valid});
        end
        n_vec++;
        if ({bc_a.data, bc_b.data, bc_c.data} !== 24'h0) begin
            n_err++; $display("FAIL reset_bc_data got=%h want=000000", {bc_a.data, bc_b.data, bc_c.data});
        end
        n_vec++;
        if ({st_a, st_b, st_c} !== 9'h0) begin
            n_err++; $display("FAIL reset_state got=%h want=0", {st_a, st_b, st_c});
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({wr_a, wr_b, wr_c} !== 3'b111) begin
            n_err++; $display("FAIL post_reset_word_ready got=%b want=111", {wr_a, wr_b, wr_c});
        end
    endtask

    task automatic test_prefix_word();
        logic [7:0] exp [9];
        bit ok;
        exp = '{8'h08, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        sel = 0; rdy_val = 1'b1; clear_logs();
        tx_q.push_back(64'h0123456789ABCDEF);
        wait_rx(9, 300, ok);
        repeat (4) @(posedge clk);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL prefix_timeout got=%0d bytes want=9", rx_q.size()); end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL prefix_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
        if (ok && acc_t.size() == 1) begin
            n_vec++;
            if (rx_t[0] !== acc_t[0] + 1) begin
                n_err++; $display("FAIL prefix_latency got=%0d want=%0d", rx_t[0] - acc_t[0], 1);
            end
            n_vec++;
            if (rx_t[1] !== acc_t[0] + 3) begin
                n_err++; $display("FAIL prefix_gap got=%0d want=%0d", rx_t[1] - acc_t[0], 3);
            end
            n_vec++;
            if (rdy_rise !== rx_t[8]) begin
                n_err++; $display("FAIL prefix_ready_return got=%0d want=%0d", rdy_rise, rx_t[8]);
            end
        end
        n_vec++;
        if (acc_t.size() !== 1) begin n_err++; $display("FAIL prefix_accepts got=%0d want=1", acc_t.size()); end
        n_vec++;
        if (consec_viol !== 0) begin n_err++; $display("FAIL prefix_consec_valid got=%0d want=0", consec_viol); end
    endtask

    task automatic test_no_prefix_timing();
        logic [7:0] exp [8];
        bit ok;
        exp = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        sel = 1; rdy_val = 1'b1; clear_logs();
        tx_q.push_back(64'hFEDCBA9876543210);
        wait_rx(8, 300, ok);
        repeat (4) @(posedge clk);
        n_vec++;
        if (!ok || rx_q.size() != 8) begin n_err++; $display("FAIL noprefix_count got=%0d want=8", rx_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL noprefix_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
        if (ok && acc_t.size() == 1) begin
            n_vec++;
            if (rx_t[0] !== acc_t[0] + 1) begin
                n_err++; $display("FAIL noprefix_latency got=%0d want=1", rx_t[0] - acc_t[0]);
            end
            for (int i = 1; i < 8; i++) begin
                n_vec++;
                if (rx_t[i] - rx_t[i-1] !== 5) begin
                    n_err++; $display("FAIL noprefix_spacing[%0d] got=%0d want=5", i, rx_t[i] - rx_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_narrow_word();
        logic [7:0] exp [6];
        bit ok;
        exp = '{8'h02, 8'h0A, 8'hBC, 8'h02, 8'h0F, 8'hFF};
        sel = 2; rdy_val = 1'b1; clear_logs();
        tx_q.push_back(64'h0ABC);
        tx_q.push_back(64'h0FFF);
        wait_rx(6, 300, ok);
        repeat (4) @(posedge clk);
        n_vec++;
        if (!ok || rx_q.size() != 6) begin n_err++; $display("FAIL narrow_count got=%0d want=6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL narrow_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] words [100];
        bit ok;
        int k;
        sel = 0; clear_logs(); rdy_random = 1'b1;
        for (int i = 0; i < 100; i++) begin
            words[i] = {$urandom(), $urandom()};
            tx_q.push_back(words[i]);
        end
        wait_rx(900, 40000, ok);
        rdy_random = 1'b0;
        repeat (4) @(posedge clk);
        n_vec++;
        if (!ok || rx_q.size() != 900) begin n_err++; $display("FAIL bp_count got=%0d want=900", rx_q.size()); end
        k = (rx_q.size() < 900) ? rx_q.size() : 900;
        for (int i = 0; i < k; i++) begin
            n_vec++;
            if (rx_q[i] !== model_byte_a(words[i / 9], i % 9)) begin
                n_err++; $display("FAIL bp_byte[%0d] got=%h want=%h", i, rx_q[i], model_byte_a(words[i / 9], i % 9));
            end
        end
        n_vec++;
        if (acc_t.size() !== 100) begin n_err++; $display("FAIL bp_accepts got=%0d want=100", acc_t.size()); end
        n_vec++;
        if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stability got=%0d want=0", stab_viol); end
        n_vec++;
        if (consec_viol !== 0) begin n_err++; $display("FAIL bp_consec_valid got=%0d want=0", consec_viol); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp [9];
        bit ok;
        bit got_valid;
        exp = '{8'h08, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78};
        sel = 0; rdy_val = 1'b1; clear_logs();
        tx_q.push_back(64'h1122334455667788);
        wait_rx(4, 300, ok);
        rdy_val = 1'b0;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL midreset_first_bytes got=%0d want=4", rx_q.size()); end
        got_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (cur_valid) begin got_valid = 1'b1; break; end
        end
        n_vec++;
        if (!got_valid) begin n_err++; $display("FAIL midreset_wait_valid got=0 want=1"); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bc_a.valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got=%b want=0", bc_a.valid); end
        n_vec++;
        if (wr_a !== 1'b0) begin n_err++; $display("FAIL midreset_word_ready got=%b want=0", wr_a); end
        n_vec++;
        if (bc_a.data !== 8'h00) begin n_err++; $display("FAIL midreset_data got=%h want=00", bc_a.data); end
        tx_q.delete();
        clear_logs();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_val = 1'b1;
        tx_q.push_back(64'hCAFEF00D12345678);
        wait_rx(9, 300, ok);
        repeat (6) @(posedge clk);
        n_vec++;
        if (!ok || rx_q.size() != 9) begin n_err++; $display("FAIL midreset_count got=%0d want=9", rx_q.size()); end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL midreset_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [18];
        bit ok;
        exp = '{8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                8'h08, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        sel = 0; rdy_val = 1'b1; clear_logs();
        tx_q.push_back(64'h0011223344556677);
        tx_q.push_back(64'h8899AABBCCDDEEFF);
        wait_rx(18, 600, ok);
        repeat (6) @(posedge clk);
        n_vec++;
        if (!ok || rx_q.size() != 18) begin n_err++; $display("FAIL b2b_count got=%0d want=18", rx_q.size()); end
        for (int i = 0; i < 18; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                n_err++; $display("FAIL b2b_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
        n_vec++;
        if (acc_t.size() !== 2) begin n_err++; $display("FAIL b2b_accepts got=%0d want=2", acc_t.size()); end
        if (acc_t.size() == 2 && rx_t.size() >= 10) begin
            n_vec++;
            if (acc_t[1] !== rx_t[8] + 1) begin
                n_err++; $display("FAIL b2b_second_accept got=%0d want=%0d", acc_t[1], rx_t[8] + 1);
            end
            n_vec++;
            if (rx_t[9] !== acc_t[1] + 1) begin
                n_err++; $display("FAIL b2b_second_latency got=%0d want=1", rx_t[9] - acc_t[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefix_word();
        test_no_prefix_timing();
        test_narrow_word();
        test_backpressure();
        test_reset_mid_word();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oclib_word_to_bc.md
Name: oclib_word_to_bc

Overview:
Serializes a wide word, accepted on a valid/ready interface, into the 8-bit byte channel (oclib_pkg::bc_8b_s / bc_8b_fb_s). Bytes go out MSB-first, optionally preceded by a length-prefix byte. It is the transmit-side partner of the byte-channel-to-word deserializer and sits between on-chip word producers and slow off-chip links (UART, PCIe mailbox). Shifting is split into fanout-limited groups so that very wide words close timing at high clock rates.

Parameters:
WordWidth, 64, payload width in bits; must be ≥8; WordBytes = ceil(WordWidth/8) must be ≤255.
ShiftFanout, 16, flops per shift group; ShiftGroups = ceil(WordWidth/ShiftFanout).
PrefixLength, oclib_pkg::True, when True a length byte equal to WordBytes is sent before the payload.

Ports:
clock  input  1  sole clock; all logic rises on posedge.
resetN  input  1  asynchronous, active-low reset.
wordData  input  WordWidth  word to transmit; sampled only at acceptance.
wordValid  input  1  producer has a word.
wordReady  output  1  block can accept a word.
bc  output  oclib_pkg::bc_8b_s  byte channel out (.data[7:0], .valid).
bcFb  input  oclib_pkg::bc_8b_fb_s  byte channel feedback (.ready).

Behaviour:
- Reset: one clock, asynchronous active-low. While resetN=0: wordReady=0, bc.valid=0, bc.data=0, state=StIdle, the shift register and counters are cleared. Asserting reset mid-word drops bc.valid immediately and discards the partial word. No partial byte is emitted after reset releases.
- Word accept: a word is accepted on the edge where wordValid && wordReady. wordReady is registered. It rises the first cycle after reset releases and whenever the state returns to StIdle. It clears on the accepting edge, so exactly one word is taken.
- Load: wordData is zero-extended at the top to WordBytes*8 bits and loaded into the shift register sreg on the accept edge. Byte k (k=0 first) = sreg[WordBytes*8-1-8k -: 8] of the loaded value.
- Byte handshake: a byte transfers on the edge where bc.valid && bcFb.ready. While bc.valid=1, bc.data is held stable. bc.valid is deasserted on the edge after the transfer and is never asserted two consecutive cycles across different bytes. bcFb.ready while bc.valid=0 is ignored.
- States:
  - StIdle: wordReady=1. On accept, go to StPrefix if PrefixLength, else StSend. bc.valid asserts the next cycle (latency 1 from accept).
  - StPrefix: bc.data=WordBytes, bc.valid=1. On transfer, go to StGap (1 cycle, valid=0), then StSend.
  - StSend: bc.data=sreg top byte, bc.valid=1. On transfer, byteCounter++. If byteCounter==WordBytes-1, go to StIdle (wordReady=1 next cycle). Otherwise start a shift and go to StShift.
  - StShift: a ShiftGroups-bit pipe is seeded with 1 at the leftmost group. Group g shifts left by 8 (taking from lower bits; the lowest byte fills with 0) when its pipe bit is set. The leftmost group shifts first and the rightmost last. When the rightmost group shifts, go to StSend.
- Timing: a byte transferred at edge M gives the next payload byte bc.valid=1 in cycle M+ShiftGroups+1.
- Back-to-back words: last byte transferred at edge M → wordReady=1 at M+1 → a word accepted at M+1 gives bc.valid=1 at M+2.
- byteCounter width is $clog2(WordBytes+1). It clears on accept and never wraps within a word.
- WordWidth not a multiple of 8: the leading pad bits of byte 0 are 0.
- wordValid/wordData changes while wordReady=0 have no effect.

Test Plan:
- WordWidth=64, PrefixLength=True, bcFb.ready tied 1, wordData=64'h0123456789ABCDEF → bytes 08,01,23,45,67,89,AB,CD,EF. bc.valid is never high two consecutive cycles. wordReady returns 1 one cycle after EF.
- PrefixLength=False, ShiftFanout=16 (4 groups), ready=1 → 8 bytes. Consecutive valid pulses are spaced exactly 5 cycles apart. The first valid is 1 cycle after accept.
- Random bcFb.ready backpressure (30% high), 100 random words → the received stream matches the MSB-first model. bc.data is stable throughout each valid window.
- WordWidth=12, PrefixLength=True, wordData=12'hABC → bytes 02,0A,BC.
- resetN pulled low after the 3rd payload byte → bc.valid=0 and wordReady=0 immediately (asynchronous). After release, the next word transmits cleanly with a fresh prefix and no stale bytes.
- wordValid held high with two queued words → exactly one accept per word. The second accept happens 1 cycle after the first word's last byte.
